i2s_audio_receiver: RTL
=======================

// Module: i2s_audio_receiver
// PURPOSE
// Receive-side counterpart of the board's I2S_BCK/I2S_LRCK/I2S_DATA output: deserialises a Philips-format I2S
// stream from an external source (ADC, loopback of our own transmitter, second board) into parallel stereo
// samples in the system clock domain. All three inputs are asynchronous; block oversamples them with clk.
// Output pair feeds guest audio mixing/capture logic and the test loopback path.
// PARAMETERS
// WIDTH        16  sample width per channel, output bits; incoming words longer are truncated, shorter zero-padded
// SYNC_STAGES  2   flip-flops in each input synchroniser (>=2)
// PORTS
// clk            in   1      system clock; must be >= 4x BCK frequency
// reset          in   1      asynchronous, active-high reset
// i2s_bck        in   1      serial bit clock (async)
// i2s_lrck       in   1      word select (async); 0 = left, 1 = right
// i2s_data       in   1      serial data, MSB first (async)
// left           out  WIDTH  last complete left sample, MSB-aligned
// right          out  WIDTH  last complete right sample, MSB-aligned
// sample_valid   out  1      one-clk pulse: left/right updated as a coherent pair
// frame_err      out  1      one-clk pulse: right word completed without a preceding left word
// BEHAVIOUR
// - Reset (async, any time): left=0, right=0, sample_valid=0, frame_err=0; synchronisers, shift reg, bit count,
//   left holding reg cleared; state -> UNLOCKED. Reset mid-word discards that word entirely.
// - Each input passes SYNC_STAGES FFs; bck_rise = synced BCK high and previous synced BCK low. All sampling of
//   lrck/data happens only on bck_rise, using synced values from the same clk cycle.
// - lrck_prev register holds LRCK from previous bck_rise. Edge slot: bck_rise with lrck != lrck_prev.
//   Philips timing: bit sampled in edge slot is LSB of the word of channel lrck_prev; word completes there.
// - Bit counter n (saturates at WIDTH): on each bit accepted, if n<WIDTH store bit at position WIDTH-1-n, n++;
//   bits beyond WIDTH dropped. Completion bit counts. Unwritten low bits are 0 (shorter words zero-padded).
//   After completion: shift reg cleared, n=0; next bck_rise bit is MSB of the new channel word.
// - States: UNLOCKED -> first edge slot after reset: word discarded (partial), go LOCKED_L or LOCKED_R per new
//   lrck. LOCKED: at each edge slot the completed word is processed:
//   * left word complete: latch into left_hold, set have_left.
//   * right word complete, have_left=1: left<=left_hold, right<=word, sample_valid pulse, have_left=0.
//   * right word complete, have_left=0: frame_err pulse, word discarded, outputs unchanged.
//   * left word complete while have_left=1: left_hold overwritten (previous left lost, no error).
// - Latency: sample_valid/frame_err assert in the clk cycle immediately after the cycle where bck_rise of the
//   edge slot is detected, i.e. SYNC_STAGES+2 clk edges after BCK rises at the pin. left/right change in the
//   same cycle sample_valid goes high and hold until next pulse.
// - No BCK activity: outputs hold indefinitely; no timeout. LRCK toggling with zero bits between edges gives a
//   word of just the LSB slot bit at MSB position (n=1), processed normally.
// - sample_valid and frame_err never high in the same cycle; each at most one cycle wide.
// TESTING
// - Reset then stream L=0x1234, R=0xABCD (WIDTH=16, 32 BCK/frame, clk=8xBCK) -> first frame discarded
//   (UNLOCKED), then each frame: sample_valid pulse with left=0x1234, right=0xABCD.
// - 24-bit words L=0x123456, R=0xFEDCBA, WIDTH=16 -> left=0x1234, right=0xFEDC (truncation).
// - 8-bit words L=0xA5, R=0x3C, WIDTH=16 -> left=0xA500, right=0x3C00 (zero pad, MSB aligned).
// - Start stream on right channel after lock glitch: LRCK held high two words (right,right) -> frame_err pulse,
//   left/right unchanged; next proper L/R pair -> sample_valid with correct values.
// - Assert reset mid-right-word, release -> outputs 0, no pulse until one full frame after first LRCK edge.
// - Latency: single BCK rise of edge slot at pin, SYNC_STAGES=2 -> sample_valid high exactly 4 clk edges later,
//   width 1; BCK stopped for 10000 clk -> outputs stable, no pulses.

Source files
------------

// File: rtl/i2s_audio_receiver_if.sv
// I2S receive bundle: serial pins in, stereo sample pair and status pulses out.
interface i2s_audio_receiver_if #(
   parameter int WIDTH = 16
);
   logic             i2s_bck;
   logic             i2s_lrck;
   logic             i2s_data;
   logic [WIDTH-1:0] left;
   logic [WIDTH-1:0] right;
   logic             sample_valid;
   logic             frame_err;

   modport master (
      output i2s_bck, i2s_lrck, i2s_data,
      input  left, right, sample_valid, frame_err
   );

   modport slave (
      input  i2s_bck, i2s_lrck, i2s_data,
      output left, right, sample_valid, frame_err
   );
endinterface

// File: rtl/i2s_audio_receiver.sv
// Philips I2S receiver: oversamples async BCK/LRCK/DATA with clk and
// emits coherent left/right pairs with a one-cycle valid pulse.
module i2s_audio_receiver #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input logic clk,
   input logic reset,
   i2s_audio_receiver_if.slave rx
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      UNLOCKED,
      LOCKED_L,
      LOCKED_R
   } state_t;

   logic [SYNC_STAGES-1:0] bck_sync;
   logic [SYNC_STAGES-1:0] lrck_sync;
   logic [SYNC_STAGES-1:0] data_sync;

   logic bck_prev;
   logic rise_q;
   logic lrck_q;
   logic data_q;

   state_t           state;
   logic             primed;
   logic             lrck_prev;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] word_in;
   logic [WIDTH-1:0] left_hold;
   logic             have_left;
   logic [WIDTH-1:0] left_r;
   logic [WIDTH-1:0] right_r;
   logic             valid_r;
   logic             err_r;
   logic             edge_slot;

   // Edge detect is registered alongside lrck/data so all three line up.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bck_sync  <= '0;
         lrck_sync <= '0;
         data_sync <= '0;
         bck_prev  <= 1'b0;
         rise_q    <= 1'b0;
         lrck_q    <= 1'b0;
         data_q    <= 1'b0;
      end else begin
         bck_sync  <= {bck_sync[SYNC_STAGES-2:0], rx.i2s_bck};
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], rx.i2s_lrck};
         data_sync <= {data_sync[SYNC_STAGES-2:0], rx.i2s_data};
         bck_prev  <= bck_sync[SYNC_STAGES-1];
         rise_q    <= bck_sync[SYNC_STAGES-1] & ~bck_prev;
         lrck_q    <= lrck_sync[SYNC_STAGES-1];
         data_q    <= data_sync[SYNC_STAGES-1];
      end
   end

   always_comb begin
      word_in = shreg;
      for (int i = 0; i < WIDTH; i++) begin
         if (cnt == CW'(WIDTH - 1 - i)) begin
            word_in[i] = data_q;
         end
      end
   end

   // The first rise after reset only seeds lrck_prev; it is never an edge.
   assign edge_slot = rise_q && primed && (lrck_q != lrck_prev);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= UNLOCKED;
         primed    <= 1'b0;
         lrck_prev <= 1'b0;
         cnt       <= '0;
         shreg     <= '0;
         left_hold <= '0;
         have_left <= 1'b0;
         left_r    <= '0;
         right_r   <= '0;
         valid_r   <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         err_r   <= 1'b0;
         if (rise_q) begin
            lrck_prev <= lrck_q;
            primed    <= 1'b1;
            if (edge_slot) begin
               shreg <= '0;
               cnt   <= '0;
               state <= lrck_q ? LOCKED_R : LOCKED_L;
               unique case (state)
                  UNLOCKED: begin
                  end
                  LOCKED_L: begin
                     left_hold <= word_in;
                     have_left <= 1'b1;
                  end
                  LOCKED_R: begin
                     if (have_left) begin
                        left_r    <= left_hold;
                        right_r   <= word_in;
                        valid_r   <= 1'b1;
                        have_left <= 1'b0;
                     end else begin
                        err_r <= 1'b1;
                     end
                  end
                  default: state <= UNLOCKED;
               endcase
            end else begin
               shreg <= word_in;
               if (cnt < CW'(WIDTH)) begin
                  cnt <= cnt + CW'(1);
               end
            end
         end
      end
   end

   assign rx.left         = left_r;
   assign rx.right        = right_r;
   assign rx.sample_valid = valid_r;
   assign rx.frame_err    = err_r;
endmodule
